// File: rtl/daq_run_sequencer_if.sv
// Command, source and SRAM-FIFO side signals of the acquisition run sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface daq_run_sequencer_if;
    logic        iStartCmd;
    logic        iStopCmd;
    logic [15:0] iWordCount;
    logic [15:0] iSrcData;
    logic        iSrcData_en;
    logic        iFull;
    logic        oRunStart;
    logic [15:0] oDataout;
    logic        oDataout_en;
    logic        oBusy;
    logic        oDone;
    logic        oOverflow;

    modport slave (
        input  iStartCmd, iStopCmd, iWordCount, iSrcData, iSrcData_en, iFull,
        output oRunStart, oDataout, oDataout_en, oBusy, oDone, oOverflow
    );

    modport master (
        output iStartCmd, iStopCmd, iWordCount, iSrcData, iSrcData_en, iFull,
        input  oRunStart, oDataout, oDataout_en, oBusy, oDone, oOverflow
    );
endinterface

// File: rtl/daq_run_sequencer.sv
// Run sequencer: gates the data source for a programmed word count and frames its stream.
// Define FRAME_CHECKSUM_EN to append a 16-bit wrapping checksum word before the trailer.
module daq_run_sequencer (
    input  logic                clk,
    input  logic                reset,
    daq_run_sequencer_if.slave  bus
);
    localparam logic [15:0] HEADER_WORD   = 16'hEB90;
    localparam logic [15:0] TRAILER_OK    = 16'h5A5A;
    localparam logic [15:0] TRAILER_ABORT = 16'hA5A5;

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_LEN, S_RUN, S_CSUM, S_TRAILER, S_DONE
    } state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_LEN, S_RUN, S_TRAILER, S_DONE
    } state_t;
    localparam state_t S_TAIL = S_TRAILER;
`endif

    state_t      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] len_q, len_d;
    logic        abort_q, abort_d;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
`endif
    logic        run_start_q, run_start_d;
    logic [15:0] dout_q, dout_d;
    logic        dout_en_q, dout_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        abort_d     = abort_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        dout_d      = dout_q;
        dout_en_d   = 1'b0;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.iStartCmd && bus.iWordCount != 16'd0) begin
                    remaining_d = bus.iWordCount;
                    len_d       = bus.iWordCount;
                    abort_d     = 1'b0;
                    ovf_d       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d      = 16'd0;
`endif
                    state_d     = S_HEADER;
                end
            end
            // A stop here wins over the pending header/len write.
            S_HEADER: begin
                if (bus.iStopCmd) begin
                    abort_d = 1'b1;
                    state_d = S_TAIL;
                end else if (!bus.iFull) begin
                    dout_d    = HEADER_WORD;
                    dout_en_d = 1'b1;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.iStopCmd) begin
                    abort_d = 1'b1;
                    state_d = S_TAIL;
                end else if (!bus.iFull) begin
                    dout_d    = len_q;
                    dout_en_d = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Dropped words still count and still feed the checksum.
                if (bus.iSrcData_en) begin
                    if (bus.iFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        dout_d    = bus.iSrcData;
                        dout_en_d = 1'b1;
                    end
`ifdef FRAME_CHECKSUM_EN
                    csum_d      = csum_q + bus.iSrcData;
`endif
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = S_TAIL;
                end
                if (bus.iStopCmd) begin
                    abort_d = 1'b1;
                    state_d = S_TAIL;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (!bus.iFull) begin
                    dout_d    = csum_q;
                    dout_en_d = 1'b1;
                    state_d   = S_TRAILER;
                end
            end
`endif
            S_TRAILER: begin
                if (!bus.iFull) begin
                    dout_d    = abort_q ? TRAILER_ABORT : TRAILER_OK;
                    dout_en_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Source enable lags RUN entry/exit by one edge.
        run_start_d = (state_q == S_RUN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 16'd0;
            len_q       <= 16'd0;
            abort_q     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= 16'd0;
`endif
            run_start_q <= 1'b0;
            dout_q      <= 16'h0000;
            dout_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            abort_q     <= abort_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            run_start_q <= run_start_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.oRunStart   = run_start_q;
    assign bus.oDataout    = dout_q;
    assign bus.oDataout_en = dout_en_q;
    assign bus.oBusy       = busy_q;
    assign bus.oDone       = done_q;
    assign bus.oOverflow   = ovf_q;
endmodule

// File: tb/tb_daq_run_sequencer.sv
// Bench for daq_run_sequencer: directed scenarios plus random frames checked against a
// frame-list model (header, len, accepted words, optional checksum, trailer).
module tb_daq_run_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    daq_run_sequencer_if bus ();
    daq_run_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] fixed_q[$];
    logic [15:0] m_sum;
    bit          m_abort;
    bit          m_ovf;
    logic        full_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) full_prev <= bus.iFull;

    always @(negedge clk) begin
        if (bus.oDataout_en === 1'b1) begin
            got_q.push_back(bus.oDataout);
            chk("write_while_full", {31'd0, full_prev}, 32'd0);
        end
    end

    task automatic model_open(input logic [15:0] n);
        exp_q.delete();
        got_q.delete();
        exp_q.push_back(16'hEB90);
        exp_q.push_back(n);
        m_sum   = 16'd0;
        m_abort = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_word(input logic [15:0] d, input logic full);
        m_sum = m_sum + d;
        if (full) m_ovf = 1'b1;
        else      exp_q.push_back(d);
    endtask

    task automatic model_close();
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(m_sum);
`endif
        exp_q.push_back(m_abort ? 16'hA5A5 : 16'h5A5A);
    endtask

    function automatic logic rnd_full(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic finish_frame(input string tag, input int full_pct);
        int b;
        b = 0;
        while (bus.oDone !== 1'b1 && b < 200) begin
            bus.iFull = rnd_full(full_pct);
            step();
            b++;
        end
        chk({tag, "_done"}, bus.oDone, 1);
        bus.iFull = 1'b0;
        step();
        chk({tag, "_done_pulse"}, bus.oDone, 0);
        chk({tag, "_idle"}, bus.oBusy, 0);
        chk({tag, "_ovf"}, bus.oOverflow, m_ovf);
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_word"}, got_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input string tag, input int n, input int stop_at,
                             input int full_pct, input bit restart);
        int b;
        int issued;
        bit stopped;
        model_open(n[15:0]);
        bus.iStartCmd  = 1'b1;
        bus.iWordCount = n[15:0];
        bus.iFull      = rnd_full(full_pct);
        step();
        bus.iStartCmd = 1'b0;
        chk({tag, "_busy"}, bus.oBusy, 1);
        chk({tag, "_ovf_clr"}, bus.oOverflow, 0);
        b = 0;
        while (bus.oRunStart !== 1'b1 && b < 100) begin
            bus.iFull = rnd_full(full_pct);
            step();
            b++;
        end
        chk({tag, "_run"}, bus.oRunStart, 1);
        issued = 0; stopped = 0; b = 0;
        while (issued < n && !stopped && b < 1000) begin
            bus.iFull = rnd_full(full_pct);
            if (fixed_q.size() > 0) begin
                bus.iSrcData    = fixed_q.pop_front();
                bus.iSrcData_en = 1'b1;
            end else begin
                bus.iSrcData    = 16'($urandom);
                bus.iSrcData_en = ($urandom_range(0, 9) < 6);
            end
            if (restart && issued == 1) begin
                bus.iStartCmd  = 1'b1;
                bus.iWordCount = 16'd7;
            end
            if (issued == stop_at) begin
                bus.iStopCmd = 1'b1;
                stopped = 1'b1;
            end
            if (bus.iSrcData_en) begin
                model_word(bus.iSrcData, bus.iFull);
                issued++;
            end
            step();
            b++;
            bus.iSrcData_en = 1'b0;
            bus.iStopCmd    = 1'b0;
            bus.iStartCmd   = 1'b0;
        end
        chk({tag, "_run_hold"}, bus.oRunStart, 1);
        m_abort = stopped;
        model_close();
        bus.iFull = rnd_full(full_pct);
        step();
        chk({tag, "_run_fall"}, bus.oRunStart, 0);
        finish_frame(tag, full_pct);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_run"},  bus.oRunStart, 0);
        chk({tag, "_dout"}, bus.oDataout, 16'h0000);
        chk({tag, "_en"},   bus.oDataout_en, 0);
        chk({tag, "_busy"}, bus.oBusy, 0);
        chk({tag, "_done"}, bus.oDone, 0);
        chk({tag, "_ovf"},  bus.oOverflow, 0);
    endtask

    initial begin
        int b;
        int n;
        int stop;
        logic [15:0] w;
        reset = 1'b1;
        bus.iStartCmd = 0; bus.iStopCmd = 0; bus.iWordCount = 0;
        bus.iSrcData = 0; bus.iSrcData_en = 0; bus.iFull = 0;
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // Normal frame with exact latencies
        model_open(16'd3);
        bus.iStartCmd = 1'b1; bus.iWordCount = 16'd3;
        step();
        bus.iStartCmd = 1'b0;
        chk("a_hdr_wait", bus.oDataout_en, 0);
        step();
        chk("a_hdr_en", bus.oDataout_en, 1);
        chk("a_hdr", bus.oDataout, 16'hEB90);
        step();
        chk("a_len_en", bus.oDataout_en, 1);
        chk("a_len", bus.oDataout, 16'h0003);
        chk("a_run_low", bus.oRunStart, 0);
        step();
        chk("a_run_high", bus.oRunStart, 1);
        for (int i = 1; i <= 3; i++) begin
            bus.iSrcData = 16'(i); bus.iSrcData_en = 1'b1;
            model_word(16'(i), 1'b0);
            step();
            bus.iSrcData_en = 1'b0;
            chk("a_data_en", bus.oDataout_en, 1);
            chk("a_data", bus.oDataout, i);
            chk("a_run_on", bus.oRunStart, 1);
        end
        model_close();
        step();
        chk("a_run_off", bus.oRunStart, 0);
`ifdef FRAME_CHECKSUM_EN
        chk("a_csum", bus.oDataout, 16'h0006);
`else
        chk("a_trailer", bus.oDataout, 16'h5A5A);
`endif
        finish_frame("a", 0);

        // Abort after two source words
        run_frame("b_abort", 10, 2, 0, 0);

        // Header backpressure, then a dropped word in RUN
        model_open(16'd2);
        bus.iFull = 1'b1;
        bus.iStartCmd = 1'b1; bus.iWordCount = 16'd2;
        step();
        bus.iStartCmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("c_stall", bus.oDataout_en, 0);
        end
        bus.iFull = 1'b0;
        step();
        chk("c_hdr_en", bus.oDataout_en, 1);
        chk("c_hdr", bus.oDataout, 16'hEB90);
        step();
        chk("c_len", bus.oDataout, 16'h0002);
        step();
        chk("c_run", bus.oRunStart, 1);
        bus.iFull = 1'b1; bus.iSrcData = 16'h1234; bus.iSrcData_en = 1'b1;
        model_word(16'h1234, 1'b1);
        step();
        chk("c_drop", bus.oDataout_en, 0);
        chk("c_ovf_set", bus.oOverflow, 1);
        bus.iFull = 1'b0; bus.iSrcData = 16'h0042;
        model_word(16'h0042, 1'b0);
        step();
        bus.iSrcData_en = 1'b0;
        chk("c_word", bus.oDataout, 16'h0042);
        model_close();
        finish_frame("c", 0);

        // Ignored commands
        bus.iStartCmd = 1'b1; bus.iWordCount = 16'd0;
        step();
        bus.iStartCmd = 1'b0;
        chk("d_zero_busy", bus.oBusy, 0);
        bus.iSrcData = 16'hBEEF; bus.iSrcData_en = 1'b1; bus.iStopCmd = 1'b1;
        step();
        bus.iSrcData_en = 1'b0; bus.iStopCmd = 1'b0;
        chk("d_idle_strobe", bus.oDataout_en, 0);
        chk("d_idle_busy", bus.oBusy, 0);
        run_frame("d_restart", 4, -1, 0, 1);

        // Stop during HEADER: no header/len, straight to tail
        model_open(16'd5);
        exp_q.delete();
        bus.iFull = 1'b1; bus.iStartCmd = 1'b1; bus.iWordCount = 16'd5;
        step();
        bus.iStartCmd = 1'b0; bus.iStopCmd = 1'b1;
        step();
        bus.iStopCmd = 1'b0; bus.iFull = 1'b0;
        m_abort = 1'b1;
        model_close();
        finish_frame("g_hdr_abort", 0);

        // Reset mid-RUN after 5 of 8 words
        model_open(16'd8);
        bus.iStartCmd = 1'b1; bus.iWordCount = 16'd8;
        step();
        bus.iStartCmd = 1'b0;
        b = 0;
        while (bus.oRunStart !== 1'b1 && b < 20) begin step(); b++; end
        chk("e_run", bus.oRunStart, 1);
        for (int i = 0; i < 5; i++) begin
            bus.iSrcData = 16'(100 + i); bus.iSrcData_en = 1'b1;
            step();
        end
        bus.iSrcData_en = 1'b0;
        reset = 1'b1;
        step();
        chk_reset_vals("e_rst");
        reset = 1'b0;
        step();
        chk("e_post_busy", bus.oBusy, 0);
        run_frame("e_clean", 8, -1, 0, 0);

        // Checksum wrap
        fixed_q.push_back(16'hFFFF);
        fixed_q.push_back(16'h0002);
        run_frame("f_wrap", 2, -1, 0, 0);
        w = (got_q.size() >= 2) ? got_q[got_q.size() - 2] : 16'hxxxx;
`ifdef FRAME_CHECKSUM_EN
        chk("f_size", got_q.size(), 6);
        chk("f_csum", w, 16'h0001);
`else
        chk("f_size", got_q.size(), 5);
        chk("f_last_data", w, 16'h0002);
`endif

        // Random frames with backpressure, aborts and stray starts
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 12);
            stop = (n >= 3 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 2) : -1;
            run_frame("rnd", n, stop, 30, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
